// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared lock bit indices, lock patterns and FSM state encoding for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int LOCK_PC    = 0;
  localparam int LOCK_IFID  = 1;
  localparam int LOCK_IDEX  = 2;
  localparam int LOCK_EXMEM = 3;
  localparam int LOCK_MEMWB = 4;

  localparam logic [4:0] LOCK_NONE  = 5'b00000;
  localparam logic [4:0] LOCK_FETCH = 5'b00001;
  localparam logic [4:0] LOCK_DEC   = 5'b00011;
  localparam logic [4:0] LOCK_MEM   = 5'b01111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - free-running wrap counters for stalled cycles and PC redirects
module pipe_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  logic [PERF_W-1:0] stall_q, stall_d;
  logic [PERF_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q + PERF_W'(stall_i);
    flush_d = flush_q + PERF_W'(flush_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard controller: lock vector, flush strobes, PC redirect
// Optional perf counters under `PIPE_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LOCK_W = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_mem_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [LOCK_W-1:0] lock_o,
  output logic              IFID_clean_o,
  output logic              IDEX_clean_o,
  output logic              MEMWB_clean_o,
  output logic              pc_redirect_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic [PERF_W-1:0] perf_stall_o,
  output logic [PERF_W-1:0] perf_flush_o
);

  pipe_state_e       state_q, state_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic [4:0]        lock;

  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    lock          = LOCK_NONE;
    IFID_clean_o  = 1'b0;
    IDEX_clean_o  = 1'b0;
    MEMWB_clean_o = 1'b0;
    pc_redirect_o = 1'b0;
    pc_target_o   = '0;
    if (rst) begin
      IFID_clean_o  = 1'b1;
      IDEX_clean_o  = 1'b1;
      MEMWB_clean_o = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // MEM stall freezes EX, so a coincident branch is simply re-presented later
          if (stallreq_mem_i) begin
            lock          = LOCK_MEM;
            MEMWB_clean_o = 1'b1;
          end else if (branch_flag_i && !stallreq_if_i) begin
            IFID_clean_o  = 1'b1;
            IDEX_clean_o  = 1'b1;
            pc_redirect_o = 1'b1;
            pc_target_o   = branch_target_i;
          end else if (branch_flag_i) begin
            IFID_clean_o  = 1'b1;
            IDEX_clean_o  = 1'b1;
            lock          = LOCK_FETCH;
            pend_target_d = branch_target_i;
            state_d       = ST_PEND;
          end else if (stallreq_id_i) begin
            lock         = LOCK_DEC;
            IDEX_clean_o = 1'b1;
          end else if (stallreq_if_i) begin
            lock         = LOCK_FETCH;
            IFID_clean_o = 1'b1;
          end
        end
        ST_PEND: begin
          IFID_clean_o = 1'b1;
          IDEX_clean_o = 1'b1;
          if (stallreq_mem_i) begin
            lock = LOCK_MEM;
          end else if (stallreq_if_i) begin
            lock = LOCK_FETCH;
          end else begin
            pc_redirect_o = 1'b1;
            pc_target_o   = pend_target_q;
            state_d       = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign lock_o = LOCK_W'(lock);

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt #(.PERF_W(PERF_W)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (lock[LOCK_PC]),
    .flush_i     (pc_redirect_o),
    .stall_cnt_o (perf_stall_o),
    .flush_cnt_o (perf_flush_o)
  );
`else
  assign perf_stall_o = '0;
  assign perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if_i = 1'b0, stallreq_id_i = 1'b0, stallreq_mem_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [4:0]  lock_o;
  logic        IFID_clean_o, IDEX_clean_o, MEMWB_clean_o, pc_redirect_o;
  logic [31:0] pc_target_o, perf_stall_o, perf_flush_o;

  int n_cmp = 0;
  int n_bad = 0;

  // reference: a pending redirect (if any) and the two event tallies
  bit          m_pending = 1'b0;
  logic [31:0] m_tgt = '0;
  int unsigned m_stalls = 0, m_flushes = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_mem_i(stallreq_mem_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .lock_o(lock_o),
    .IFID_clean_o(IFID_clean_o), .IDEX_clean_o(IDEX_clean_o),
    .MEMWB_clean_o(MEMWB_clean_o), .pc_redirect_o(pc_redirect_o),
    .pc_target_o(pc_target_o), .perf_stall_o(perf_stall_o),
    .perf_flush_o(perf_flush_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs (called just after a falling edge), check the
  // combinational response, then advance the reference across the rising edge.
  task automatic cyc(input bit r, input bit sm, input bit sd, input bit sf,
                     input bit b, input logic [31:0] t);
    logic [4:0]  e_lock;
    bit          e_ifid, e_idex, e_memwb, e_redir;
    logic [31:0] e_tgt;
    rst = r; stallreq_mem_i = sm; stallreq_id_i = sd; stallreq_if_i = sf;
    branch_flag_i = b; branch_target_i = t;
    #1;
    e_lock = 5'b0; e_ifid = 0; e_idex = 0; e_memwb = 0; e_redir = 0; e_tgt = '0;
    if (r) begin
      m_pending = 0; m_tgt = '0; m_stalls = 0; m_flushes = 0;
      e_ifid = 1; e_idex = 1; e_memwb = 1;
    end else if (m_pending) begin
      e_ifid = 1; e_idex = 1;
      if (sm)      e_lock = 5'b01111;
      else if (sf) e_lock = 5'b00001;
      else begin e_redir = 1; e_tgt = m_tgt; end
    end else if (sm) begin
      e_lock = 5'b01111; e_memwb = 1;
    end else if (b) begin
      e_ifid = 1; e_idex = 1;
      if (sf) e_lock = 5'b00001;
      else begin e_redir = 1; e_tgt = t; end
    end else if (sd) begin
      e_lock = 5'b00011; e_idex = 1;
    end else if (sf) begin
      e_lock = 5'b00001; e_ifid = 1;
    end
    check("lock", 64'(lock_o), 64'(e_lock));
    check("ifid_clean", 64'(IFID_clean_o), 64'(e_ifid));
    check("idex_clean", 64'(IDEX_clean_o), 64'(e_idex));
    check("memwb_clean", 64'(MEMWB_clean_o), 64'(e_memwb));
    check("redirect", 64'(pc_redirect_o), 64'(e_redir));
    if (r || e_redir) check("target", 64'(pc_target_o), 64'(e_tgt));
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall", 64'(perf_stall_o), 64'(m_stalls));
    check("perf_flush", 64'(perf_flush_o), 64'(m_flushes));
`else
    check("perf_stall", 64'(perf_stall_o), 64'd0);
    check("perf_flush", 64'(perf_flush_o), 64'd0);
`endif
    @(posedge clk);
    if (!r) begin
      if (e_lock[0]) m_stalls++;
      if (e_redir) m_flushes++;
      if (!m_pending && !sm && b && sf) begin m_pending = 1; m_tgt = t; end
      else if (m_pending && !sm && !sf) m_pending = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 32'hdead_beef);
    // load-use stall then release, then branch with IF stalled 3 cycles
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h0000_0200);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h0000_0bad);
    cyc(0, 0, 0, 0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall_t6", 64'(perf_stall_o), 64'd4);
    check("perf_flush_t6", 64'(perf_flush_o), 64'd1);
`endif
    cyc(0, 0, 0, 0, 1, 32'h0000_0100);
    cyc(0, 1, 0, 0, 1, 32'h0000_0300);
    // mem stall while pending, then reset drops the pending redirect
    cyc(0, 0, 0, 1, 1, 32'h0000_0400);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) < 2), ($urandom_range(99) < 15), ($urandom_range(99) < 20),
          ($urandom_range(99) < 35), ($urandom_range(99) < 25), $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
